// File: rtl/hazard_stall_ctrl.sv
// Stall controller for the 5-stage MIPS core: Tuse/Tnew register hazards plus a
// busy tracker for the multi-cycle multiply/divide unit, with error flag and stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_uses_md,
    input  logic [4:0]  E_rd_w,
    input  logic [4:0]  M_rd_w,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        E_flush,
    output logic        md_busy,
    output logic [3:0]  busy_cnt,
    output logic        err,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic hazard_rs, hazard_rt, hazard_md;

    always_comb begin
        hazard_rs = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
                    (((E_rd_w == D_rs) && (E_tnew > D_tuse_rs)) ||
                     ((M_rd_w == D_rs) && (M_tnew > D_tuse_rs)));
        hazard_rt = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
                    (((E_rd_w == D_rt) && (E_tnew > D_tuse_rt)) ||
                     ((M_rd_w == D_rt) && (M_tnew > D_tuse_rt)));
    end

    // Outputs are gated by reset so they read 0 while it is held low, whatever the inputs.
    assign md_busy   = reset & (E_start | (cnt_q != 4'd0));
    assign hazard_md = D_uses_md & md_busy;
    assign stall     = reset & (hazard_rs | hazard_rt | hazard_md);
    assign E_flush   = stall;

    assign busy_cnt     = cnt_q;
    assign err          = err_q;
    assign stall_cycles = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (E_start) begin
                    cnt_d   = E_is_div ? DivCnt : MultCnt;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A start while busy is dropped; only the error flag records it.
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = StIdle;
                end
                if (E_start) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; inputs change 1ns after the
// rising edge and outputs are checked 3ns after it, well clear of the next edge.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_rd_w, M_rd_w;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_uses_md, E_start, E_is_div;
    logic        stall, E_flush, md_busy, err;
    logic [3:0]  busy_cnt;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_tuse_rs    (D_tuse_rs),
        .D_tuse_rt    (D_tuse_rt),
        .D_uses_md    (D_uses_md),
        .E_rd_w       (E_rd_w),
        .M_rd_w       (M_rd_w),
        .E_tnew       (E_tnew),
        .M_tnew       (M_tnew),
        .E_start      (E_start),
        .E_is_div     (E_is_div),
        .stall        (stall),
        .E_flush      (E_flush),
        .md_busy      (md_busy),
        .busy_cnt     (busy_cnt),
        .err          (err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_uses_md = 1'b0;
        E_rd_w = 5'd0; M_rd_w = 5'd0; E_tnew = 2'd0; M_tnew = 2'd0;
        E_start = 1'b0; E_is_div = 1'b0;
    endtask

    // Advance to 1ns after the next rising edge (start of the next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        E_start = 1'b1; D_uses_md = 1'b1;
        E_rd_w = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
        tick(); tick(); tick();
        #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (E_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", E_flush); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
        total++; if (busy_cnt !== 4'd0) begin bad++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        E_rd_w = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
        #2;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        total++; if (E_flush !== 1'b1) begin bad++; $display("FAIL lu_flush got=%b exp=1", E_flush); end
        E_tnew = 2'd1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_tnew_eq got=%b exp=0", stall); end
        E_tnew = 2'd2; D_rs = 5'd0; E_rd_w = 5'd0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b exp=0", stall); end
        clear_inputs();
        M_rd_w = 5'd9; M_tnew = 2'd1; D_rt = 5'd9; D_tuse_rt = 2'd0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL m_rt_stall got=%b exp=1", stall); end
        D_tuse_rt = 2'd3;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL m_rt_unused got=%b exp=0", stall); end
        clear_inputs();
        tick();
    endtask

    task automatic test_mult_read();
        do_reset();
        E_start = 1'b1; E_is_div = 1'b0;
        #2;
        total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL mul_busy_c0 got=%b exp=1", md_busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mul_stall_c0 got=%b exp=0", stall); end
        tick();
        E_start = 1'b0; D_uses_md = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            // Overlapping register hazard in cycle 2 must not double-count.
            if (k == 2) begin E_rd_w = 5'd4; E_tnew = 2'd2; D_rs = 5'd4; D_tuse_rs = 2'd0; end
            else begin E_rd_w = 5'd0; D_rs = 5'd0; end
            #2;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall c%0d got=%b exp=1", k, stall); end
            total++; if (busy_cnt !== 4'(6 - k)) begin bad++; $display("FAIL mul_cnt c%0d got=%0d exp=%0d", k, busy_cnt, 6 - k); end
            tick();
        end
        #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mul_stall_c6 got=%b exp=0", stall); end
        total++; if (busy_cnt !== 4'd0) begin bad++; $display("FAIL mul_cnt_c6 got=%0d exp=0", busy_cnt); end
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=5", stall_cycles); end
        clear_inputs();
        tick();
    endtask

    task automatic test_div();
        do_reset();
        E_start = 1'b1; E_is_div = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            #2;
            total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL div_busy c%0d got=%b exp=1", k, md_busy); end
            if (k >= 1) begin
                total++; if (busy_cnt !== 4'(11 - k)) begin bad++; $display("FAIL div_cnt c%0d got=%0d exp=%0d", k, busy_cnt, 11 - k); end
            end
            tick();
            E_start = 1'b0; E_is_div = 1'b0;
        end
        E_start = 1'b1; E_is_div = 1'b0;
        #2;
        total++; if (busy_cnt !== 4'd0) begin bad++; $display("FAIL div_cnt_c11 got=%0d exp=0", busy_cnt); end
        tick();
        E_start = 1'b0;
        #2;
        total++; if (busy_cnt !== 4'd5) begin bad++; $display("FAIL div_restart_cnt got=%0d exp=5", busy_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL div_restart_err got=%b exp=0", err); end
        clear_inputs();
        tick();
    endtask

    task automatic test_illegal_start();
        logic [3:0] exp_cnt [3];
        exp_cnt[0] = 4'd2; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd0;
        do_reset();
        E_start = 1'b1;
        tick();
        E_start = 1'b0;
        tick(); tick();
        E_start = 1'b1;
        #2;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_before got=%b exp=0", err); end
        tick();
        E_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            total++; if (busy_cnt !== exp_cnt[k]) begin bad++; $display("FAIL ill_cnt c%0d got=%0d exp=%0d", k + 4, busy_cnt, exp_cnt[k]); end
            total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err c%0d got=%b exp=1", k + 4, err); end
            tick();
        end
        tick(); tick();
        #2;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err_sticky got=%b exp=1", err); end
        do_reset();
        #2;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_cleared got=%b exp=0", err); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        E_start = 1'b1; E_is_div = 1'b1;
        tick();
        E_start = 1'b0; E_is_div = 1'b0;
        tick(); tick(); tick();
        #2;
        total++; if (busy_cnt !== 4'd7) begin bad++; $display("FAIL mid_cnt_c4 got=%0d exp=7", busy_cnt); end
        reset = 1'b0;
        #1;
        total++; if (busy_cnt !== 4'd0) begin bad++; $display("FAIL mid_cnt_async got=%0d exp=0", busy_cnt); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_async got=%b exp=0", md_busy); end
        tick();
        reset = 1'b1;
        tick();
        E_start = 1'b1;
        tick();
        E_start = 1'b0;
        #2;
        total++; if (busy_cnt !== 4'd5) begin bad++; $display("FAIL mid_restart_cnt got=%0d exp=5", busy_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_restart_err got=%b exp=0", err); end
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_mult_read();
        test_div();
        test_illegal_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
